// File: rtl/led_pulse_pkg.sv
// Shared constants and helpers for the multi-channel LED pulse bank.
// Build option: LED_PULSE_STAGGER_EN spreads the breathe start brightness across channels.
package led_pulse_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

`ifdef LED_PULSE_STAGGER_EN
    localparam int STAGGER_EN = 1;
`else
    localparam int STAGGER_EN = 0;
`endif

    // Counter width for a modulo-n prescaler, never narrower than one bit.
    function automatic int cnt_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Breathe start brightness for channel idx; phase-offset only when staggering.
    function automatic int b_init(input int idx, input int num_ch, input int pwm_w);
        int stagger;
        stagger = (idx * ((1 << pwm_w) - 1)) / num_ch;
        if (STAGGER_EN != 0) begin
            return stagger;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/led_pulse_channel.sv
// One LED channel: registered mode, triangular brightness ramp and registered LED drive.
// Shared PWM count, step event and blink phase come from led_pulse_bank.
module led_pulse_channel
    import led_pulse_pkg::*;
#(
    parameter int PWM_W  = 8,
    parameter int B_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_mode,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    input  logic             i_step_ev,
    input  logic             i_blink_ph,
    output logic             o_led
);

    localparam logic [PWM_W-1:0] B_INIT_V = B_INIT[PWM_W-1:0];
    localparam logic [PWM_W-1:0] B_MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] B_ZERO   = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0] B_ONE    = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_mode_q;
    logic [PWM_W-1:0] r_b;
    logic             r_dir;
    logic             r_led;

    logic             w_entry;
    logic [PWM_W-1:0] w_b_nxt;
    logic             w_dir_nxt;
    logic             w_led_nxt;

    // Entry into BREATHE is seen on the edge that loads mode_q with 11.
    assign w_entry = (i_mode == MODE_BREATHE) && (r_mode_q != MODE_BREATHE);

    // Ramp next state: entry reloads, a step event walks the triangle, otherwise hold.
    always_comb begin
        w_b_nxt   = r_b;
        w_dir_nxt = r_dir;
        if (w_entry) begin
            w_b_nxt   = B_INIT_V;
            w_dir_nxt = DIR_UP;
        end else if ((r_mode_q == MODE_BREATHE) && i_step_ev) begin
            if (r_dir == DIR_UP) begin
                if (r_b == B_MAX) begin
                    w_dir_nxt = DIR_DOWN;
                    w_b_nxt   = B_MAX - B_ONE;
                end else begin
                    w_b_nxt   = r_b + B_ONE;
                end
            end else begin
                if (r_b == B_ZERO) begin
                    w_dir_nxt = DIR_UP;
                    w_b_nxt   = B_ONE;
                end else begin
                    w_b_nxt   = r_b - B_ONE;
                end
            end
        end else begin
            w_b_nxt   = r_b;
            w_dir_nxt = r_dir;
        end
    end

    // LED next value selected by the already-registered mode.
    always_comb begin
        w_led_nxt = 1'b0;
        case (r_mode_q)
            MODE_OFF:     w_led_nxt = 1'b0;
            MODE_ON:      w_led_nxt = 1'b1;
            MODE_BLINK:   w_led_nxt = i_blink_ph;
            MODE_BREATHE: w_led_nxt = (i_pwm_cnt < r_b);
            default:      w_led_nxt = 1'b0;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= MODE_OFF;
            r_b      <= B_INIT_V;
            r_dir    <= DIR_UP;
            r_led    <= 1'b0;
        end else begin
            r_mode_q <= i_mode;
            r_b      <= w_b_nxt;
            r_dir    <= w_dir_nxt;
            r_led    <= w_led_nxt;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_pulse_bank.sv
// Multi-channel LED driver (OFF/ON/BLINK/BREATHE) with shared prescalers and PWM counter.
// Build option: LED_PULSE_STAGGER_EN phase-offsets the breathe start of each channel.
module led_pulse_bank
    import led_pulse_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int PWM_W     = 8,
    parameter int STEP_DIV  = 23438,
    parameter int BLINK_DIV = 6000000
) (
    input  logic                  clk,
    input  logic                  rst_btn,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic [NUM_CH-1:0]     led,
    output logic                  step_tick
);

    localparam int SW = cnt_w(STEP_DIV);
    localparam int BW = cnt_w(BLINK_DIV);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] STEP_ONE   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BLINK_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] PWM_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [SW-1:0]    r_step_cnt;
    logic [BW-1:0]    r_blink_cnt;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             r_blink_ph;
    logic             r_step_tick;

    logic             w_step_ev;
    logic             w_blink_wrap;
    logic [NUM_CH-1:0] w_led;

    assign w_step_ev    = (r_step_cnt == STEP_LAST);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

    // Shared step/blink prescalers and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_step_cnt  <= {SW{1'b0}};
            r_blink_cnt <= {BW{1'b0}};
            r_pwm_cnt   <= {PWM_W{1'b0}};
            r_blink_ph  <= 1'b0;
            r_step_tick <= 1'b0;
        end else begin
            r_step_cnt  <= w_step_ev ? {SW{1'b0}} : (r_step_cnt + STEP_ONE);
            r_blink_cnt <= w_blink_wrap ? {BW{1'b0}} : (r_blink_cnt + BLINK_ONE);
            r_blink_ph  <= w_blink_wrap ? ~r_blink_ph : r_blink_ph;
            r_pwm_cnt   <= r_pwm_cnt + PWM_ONE;
            r_step_tick <= w_step_ev;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pulse_channel #(
            .PWM_W  (PWM_W),
            .B_INIT (b_init(g, NUM_CH, PWM_W))
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_btn),
            .i_mode     (mode[2*g+1:2*g]),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_step_ev  (w_step_ev),
            .i_blink_ph (r_blink_ph),
            .o_led      (w_led[g])
        );
    end

    assign led       = w_led;
    assign step_tick = r_step_tick;

endmodule

// File: tb/tb_led_pulse_bank.sv
// Scoreboard bench for led_pulse_bank at NUM_CH=2, PWM_W=3, STEP_DIV=4, BLINK_DIV=8.
// Stimulus queues per-cycle expectations; an independent monitor pops and compares them.
module tb_led_pulse_bank;

    typedef struct {
        int         cyc;
        logic [1:0] led;
        logic       tick;
        string      nm;
    } exp_t;

`ifdef LED_PULSE_STAGGER_EN
    localparam int OFF1 = 3;
`else
    localparam int OFF1 = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic [3:0] mode = 4'b0000;
    logic [1:0] led;
    logic       step_tick;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    led_pulse_bank #(
        .NUM_CH    (2),
        .PWM_W     (3),
        .STEP_DIV  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk       (clk),
        .rst_btn   (rst_btn),
        .mode      (mode),
        .led       (led),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    // Clock count since reset release: cycle k is the state after the k-th rising edge.
    always @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Scoreboard monitor: compare the queued expectation for this cycle, if any.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            errors++;
            $display("FAIL %s cyc=%0d: expectation never sampled (now cyc %0d)", e.nm, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if (led !== e.led || step_tick !== e.tick) begin
                errors++;
                $display("FAIL %s cyc=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         e.nm, e.cyc, led, step_tick, e.led, e.tick);
            end
        end
    end

    function automatic logic exp_tick(input int c);
        return (c >= 4) && (c % 4 == 0);
    endfunction

    // Triangle brightness after s steps from b=0 going up (MAX=7, period 14 steps).
    function automatic int tri_b(input int s);
        int m;
        m = s % 14;
        return (m <= 7) ? m : 14 - m;
    endfunction

    // BREATHE led at cycle k: previous cycle's PWM count against previous brightness.
    function automatic logic br_led(input int k, input int b);
        return ((k - 1) % 8) < b;
    endfunction

    task automatic push_exp(input int c, input logic [1:0] l, input string nm);
        exp_t x;
        x.cyc  = c;
        x.led  = l;
        x.tick = exp_tick(c);
        x.nm   = nm;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            errors++;
            $display("FAIL wait_cyc: reached cyc=%0d, expected cyc=%0d", cyc, n);
        end
        #1;
    endtask

    task automatic do_reset(input logic [3:0] m);
        mode    = m;
        rst_btn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_btn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // ON then OFF on ch0.
        do_reset(4'b0000);
        for (int k = 1; k <= 9; k++) begin
            push_exp(k, (k >= 4 && k <= 7) ? 2'b01 : 2'b00, "onoff");
        end
        wait_cyc(2);
        mode = 4'b0001;
        wait_cyc(6);
        mode = 4'b0000;
        wait_cyc(9);

        // Both channels BLINK from reset: first lit at cycle 9, toggling every 8.
        do_reset(4'b1010);
        for (int k = 1; k <= 26; k++) begin
            push_exp(k, (((k - 1) / 8) % 2 == 1) ? 2'b11 : 2'b00, "blink");
        end
        wait_cyc(26);

        // ch0 BREATHE from reset, ch1 OFF; then asynchronous reset mid-ramp.
        do_reset(4'b0011);
        for (int k = 1; k <= 27; k++) begin
            push_exp(k, {1'b0, (k == 1) ? 1'b0 : br_led(k, tri_b((k - 1) / 4))}, "breathe");
        end
        wait_cyc(27);
        @(posedge clk);
        #2;
        mode    = 4'b0000;
        rst_btn = 1'b0;
        push_exp(0, 2'b00, "async_rst");
        @(negedge clk);
        #1;
        @(posedge clk);
        #2 rst_btn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push_exp(k, 2'b00, "idle_after_rst");
        end
        wait_cyc(4);

        // Both BREATHE; ch0 leaves to ON at b=5 and re-enters, ch1 keeps its ramp.
        do_reset(4'b1111);
        for (int k = 1; k <= 60; k++) begin
            logic l0;
            logic l1;
            if (k == 1) begin
                l0 = 1'b0;
                l1 = 1'b0;
            end else begin
                l1 = br_led(k, tri_b((k - 1) / 4 + OFF1));
                if (k <= 22)      l0 = br_led(k, tri_b((k - 1) / 4));
                else if (k <= 26) l0 = 1'b1;
                else              l0 = br_led(k, tri_b((k - 1) / 4 - 6));
            end
            push_exp(k, {l1, l0}, "reentry");
        end
        wait_cyc(21);
        mode = 4'b1101;
        wait_cyc(25);
        mode = 4'b1111;
        wait_cyc(60);

        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            errors++;
            $display("FAIL %s cyc=%0d: expectation left unchecked at end", e.nm, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
